// File: rtl/frame_gen_ctrl.sv
// frame_gen_ctrl: sequences the RGB pattern generator's timing preset and pattern mode,
// applying changes only at frame boundaries and holding the generator in reset while new timing settles.
module frame_gen_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 2**22,
    parameter int FPP_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_n,
    input  logic             auto_en,
    input  logic [3:0]       mode_in,
    input  logic [FPP_W-1:0] frames_per_pattern,
    input  logic             cfg_req,
    input  logic [1:0]       cfg_sel,
    output logic             cfg_ack,
    output logic [3:0]       mode,
    output logic [21:0]      resolution,
    output logic [31:0]      Hfrporch_Vfrporch,
    output logic [31:0]      Hbkporch_Vbkporch,
    output logic [31:0]      Hsyncpulse_Vsyncpulse,
    output logic             gen_reset_n,
    output logic             busy,
    output logic [1:0]       active_preset
);
    localparam int HW = $clog2(RST_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] RST_HOLD = 2'd0;
    localparam logic [1:0] SETTLE   = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;
    localparam logic [1:0] WAIT_VS  = 2'd3;

    typedef struct packed {
        logic [10:0] w;
        logic [10:0] h;
        logic [8:0]  hf;
        logic [8:0]  hs;
        logic [8:0]  hb;
        logic [5:0]  vf;
        logic [5:0]  vs;
        logic [7:0]  vb;
    } timing_t;

    function automatic timing_t preset_tim(input logic [1:0] p);
        case (p)
            2'd0:    preset_tim = {11'd640,  11'd480,  9'd16, 9'd96,  9'd48,  6'd10, 6'd2, 8'd33};
            2'd1:    preset_tim = {11'd800,  11'd600,  9'd40, 9'd128, 9'd88,  6'd1,  6'd4, 8'd23};
            2'd2:    preset_tim = {11'd1024, 11'd768,  9'd24, 9'd136, 9'd160, 6'd3,  6'd6, 8'd29};
            default: preset_tim = {11'd1280, 11'd1024, 9'd48, 9'd112, 9'd248, 6'd1,  6'd3, 8'd38};
        endcase
    endfunction

    localparam timing_t T0 = preset_tim(2'd0);

    logic [1:0]       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             vs_q;
    logic             gen_q, gen_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       preset_q, preset_d;
    logic [3:0]       mode_q, mode_d;
    logic [FPP_W-1:0] fcnt_q, fcnt_d;
    logic [FPP_W-1:0] fpp_last;
    timing_t          tim_q, tim_d;
    logic             bnd, to_hit, load;

    always_comb begin
        bnd      = vs_q & ~vsync_n & gen_q;
        to_hit   = to_cnt_q == TW'(TIMEOUT - 1);
        state_d  = state_q;
        hold_d   = '0;
        gen_d    = gen_q;
        ack_d    = 1'b0;
        pend_d   = pend_q;
        load     = 1'b0;
        case (state_q)
            RST_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(RST_CYCLES - 1)) begin
                    state_d = SETTLE;
                    gen_d   = 1'b1;
                    hold_d  = '0;
                end
            end
            SETTLE: state_d = (bnd || to_hit) ? RUN : SETTLE;
            RUN: begin
                if (cfg_req) begin
                    ack_d   = 1'b1;
                    pend_d  = cfg_sel;
                    state_d = WAIT_VS;
                end
            end
            default: begin
                if (bnd || to_hit) begin
                    load    = 1'b1;
                    gen_d   = 1'b0;
                    state_d = RST_HOLD;
                end
            end
        endcase
        preset_d = load ? pend_q : preset_q;
        tim_d    = load ? preset_tim(pend_q) : tim_q;
        // The wait counter only runs while staying in a boundary-waiting state, so it starts at 0 on entry.
        to_cnt_d = ((state_q == SETTLE || state_q == WAIT_VS) && state_d == state_q) ? to_cnt_q + 1'b1 : '0;
        busy_d   = state_d != RUN;
    end

    always_comb begin
        fpp_last = (frames_per_pattern == '0) ? '0 : frames_per_pattern - 1'b1;
        mode_d   = mode_q;
        fcnt_d   = fcnt_q;
        if (bnd && (state_q == RUN || state_q == WAIT_VS)) begin
            if (!auto_en) begin
                mode_d = mode_in;
                fcnt_d = '0;
            end else if (fcnt_q >= fpp_last) begin
                mode_d = (mode_q == 4'd7) ? 4'd0 : mode_q + 4'd1;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        vs_q <= vsync_n;
        if (reset) begin
            state_q  <= RST_HOLD;
            hold_q   <= '0;
            to_cnt_q <= '0;
            gen_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b1;
            pend_q   <= 2'd0;
            preset_q <= 2'd0;
            mode_q   <= 4'd0;
            fcnt_q   <= '0;
            tim_q    <= T0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            to_cnt_q <= to_cnt_d;
            gen_q    <= gen_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            preset_q <= preset_d;
            mode_q   <= mode_d;
            fcnt_q   <= fcnt_d;
            tim_q    <= tim_d;
        end
    end

    assign cfg_ack               = ack_q;
    assign mode                  = mode_q;
    assign gen_reset_n           = gen_q;
    assign busy                  = busy_q;
    assign active_preset         = preset_q;
    assign resolution            = {tim_q.w, tim_q.h};
    assign Hfrporch_Vfrporch     = {7'b0, tim_q.hf, 10'b0, tim_q.vf};
    assign Hbkporch_Vbkporch     = {7'b0, tim_q.hb, 8'b0, tim_q.vb};
    assign Hsyncpulse_Vsyncpulse = {7'b0, tim_q.hs, 10'b0, tim_q.vs};
endmodule

// File: doc/frame_gen_ctrl.md
Name: frame_gen_ctrl

Overview:
Controller that sequences and configures the RGB test-pattern generator. It owns the generator's timing words (resolution, porches, sync widths) and its pattern mode. It selects one of four timing presets and applies mode or preset changes only at frame boundaries. On timing changes it holds the generator in reset long enough for its internal timing pipeline to settle.

Parameters:
RST_CYCLES, 4, generator reset hold length in clk cycles after new timing is driven; must be >= 3 (generator timing pipeline depth)
TIMEOUT, 2^22, max cycles waiting for a frame boundary before forcing a pending timing change
FPP_W, 8, width of frames-per-pattern count

Ports:
clk  in  1  pixel clock, shared with generator
reset  in  1  synchronous, active-high
vsync_n  in  1  generator vsync output (active-low); frame boundary = registered 1->0 transition
auto_en  in  1  1: auto-cycle modes 0..7; 0: manual mode
mode_in  in  4  manual pattern mode
frames_per_pattern  in  FPP_W  frames shown per mode in auto; 0 treated as 1
cfg_req  in  1  request preset change (level, held until ack)
cfg_sel  in  2  preset index, sampled when cfg_ack=1
cfg_ack  out  1  one-cycle acceptance pulse
mode  out  4  to generator mode
resolution  out  22  {width[21:11], height[10:0]}
Hfrporch_Vfrporch  out  32  {7'b0, H[24:16], 10'b0, V[5:0]} (V field width per word: front 6, back 8, sync 6 bits)
Hbkporch_Vbkporch  out  32  H back [24:16], V back [7:0], other bits 0
Hsyncpulse_Vsyncpulse  out  32  H sync [24:16], V sync [5:0], other bits 0
gen_reset_n  out  1  active-low reset to generator
busy  out  1  1 in any state other than RUN
active_preset  out  2  preset currently driven

Behaviour:
- Presets, as H front/sync/back and V front/sync/back:
  - 0 = 640x480: 16/96/48, 10/2/33
  - 1 = 800x600: 40/128/88, 1/4/23
  - 2 = 1024x768: 24/136/160, 3/6/29
  - 3 = 1280x1024: 48/112/248, 1/3/38
- Boundary detect: vs_q <= vsync_n; boundary = vs_q & ~vsync_n (1 cycle). Ignored while gen_reset_n=0.
- FSM states: RST_HOLD, SETTLE, RUN, WAIT_VS.
- Reset:
  - State RST_HOLD, active_preset=0, timing outputs = preset 0.
  - mode=0, gen_reset_n=0, cfg_ack=0, busy=1.
  - Frame counter=0, hold counter=0.
- RST_HOLD: gen_reset_n=0 for RST_CYCLES cycles, then SETTLE.
- SETTLE: gen_reset_n=1, wait for the first boundary (or TIMEOUT), then RUN. Mode updates are frozen.
- RUN:
  - If cfg_req: cfg_ack=1 for one cycle, latch cfg_sel into pend_sel, go to WAIT_VS.
  - cfg_ack never asserts outside RUN.
- WAIT_VS:
  - On boundary or timeout-counter = TIMEOUT-1: active_preset<=pend_sel, timing outputs update that cycle.
  - gen_reset_n<=0, go to RST_HOLD.
  - Timing outputs change only on this transition or on reset.
- Mode, in RUN and WAIT_VS only, updated on a boundary cycle:
  - Manual: mode<=mode_in. Frame counter held at 0.
  - Auto: if frame counter >= max(frames_per_pattern,1)-1, then mode<=(mode==7)?0:mode+1 and counter<=0; else counter++.
  - Leaving auto for manual takes mode_in at the next boundary. Entering auto starts counting from the current mode, counter 0.
- Simultaneous events:
  - cfg_req and boundary in RUN: mode update for that boundary happens; preset waits for the next boundary.
  - Boundary in WAIT_VS: mode update and preset load occur in the same cycle.
- Reset mid-operation (any state): returns to reset values; pending request is discarded; a held cfg_req is re-acknowledged after the next SETTLE.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset 3 cycles, release, model generator with vsync_n -> gen_reset_n low exactly 4 cycles after reset falls; resolution=22'h140_1E0 (640<<11|480); Hsyncpulse_Vsyncpulse=32'h0060_0002; busy drops at first vsync_n falling edge.
2. Auto, frames_per_pattern=2, 20 frames -> mode sequence 0,0,1,1,...,7,7,0,0; change coincides with the cycle after the vsync_n fall.
3. Manual, mode_in changed 0->6 mid-frame -> mode stays 0 until the next boundary, then 6; no change between boundaries.
4. cfg_req with cfg_sel=2 in RUN -> cfg_ack single pulse; timing outputs unchanged until the boundary. Then resolution=22'h200_300, Hbkporch_Vbkporch=32'h00A0_001D, gen_reset_n low 4 cycles, busy until the next boundary.
5. In WAIT_VS, force vsync_n stuck at 1, TIMEOUT=16 -> preset applied after exactly 16 cycles, then RST_HOLD.
6. Assert reset during RST_HOLD after a preset-3 request -> preset 0 restored, mode=0, cfg_ack=0; a held cfg_req is acknowledged again only after SETTLE completes.
